// File: rtl/grover_oracle_stream_pkg.sv
// Shared defaults and the saturating-negate helper for the Grover oracle and diffusion stages.
package grover_pkg;

  localparam int unsigned NUM_BIT_DEF = 3;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned SAT_W       = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] result;
    logic                    saturated;
  } sat_t;

  // x is a w-bit value sign-extended to SAT_W; the result is w-bit valid, sign-extended.
  function automatic sat_t sat_neg(input logic signed [SAT_W-1:0] x, input int unsigned w);
    sat_t                    res;
    logic signed [SAT_W-1:0] min_v;
    min_v         = {SAT_W{1'b1}} << (w - 1);
    res.saturated = (x == min_v);
    res.result    = res.saturated ? ~min_v : -x;
    return res;
  endfunction

endpackage

// File: rtl/grover_oracle_stream_if.sv
// Input/output stream handshake bundle for the Grover phase oracle.
interface grover_oracle_stream_if
  import grover_pkg::*;
#(
  parameter int unsigned NUM_BIT = NUM_BIT_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [NUM_BIT-1:0]       out_index;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/grover_oracle_stream_sat_negate.sv
// Combinational saturating negation of a signed DATA_W-bit value.
module sat_negate
  import grover_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] a,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);
  logic signed [SAT_W-1:0] a_ext;
  sat_t                    res;
  logic                    unused_hi;

  assign a_ext     = {{(SAT_W - DATA_W){a[DATA_W-1]}}, a};
  assign res       = sat_neg(a_ext, DATA_W);
  assign y         = res.result[DATA_W-1:0];
  assign sat       = res.saturated;
  assign unused_hi = ^res.result[SAT_W-1:DATA_W];
endmodule

// File: rtl/grover_oracle_stream.sv
// Streaming phase oracle: negates (with saturation) amplitudes whose basis index is marked.
module grover_oracle_stream
  import grover_pkg::*;
#(
  parameter int unsigned NUM_BIT = NUM_BIT_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [(1<<NUM_BIT)-1:0]   cfg_mask,
  input  logic                      cfg_bypass,
  output logic                      sat_flag,
  grover_oracle_stream_if.slave     bus
);
  localparam int unsigned N = 1 << NUM_BIT;

  logic [N-1:0]             shadow_mask, active_mask, frame_mask;
  logic                     shadow_bypass, active_bypass, frame_bypass;
  logic [NUM_BIT-1:0]       idx;
  logic                     accept, marked, neg_sat;
  logic signed [DATA_W-1:0] neg_data;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // The index-0 beat already belongs to the new frame, so it sees the shadow directly.
  always_comb begin
    frame_mask   = active_mask;
    frame_bypass = active_bypass;
    if (idx == '0) begin
      frame_mask   = shadow_mask;
      frame_bypass = shadow_bypass;
    end
    marked = !frame_bypass && frame_mask[idx];
  end

  sat_negate #(.DATA_W(DATA_W)) u_negate (
    .a   (bus.in_data),
    .y   (neg_data),
    .sat (neg_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_mask   <= '0;
      shadow_bypass <= 1'b0;
      active_mask   <= '0;
      active_bypass <= 1'b0;
      idx           <= '0;
    end else begin
      if (cfg_we) begin
        shadow_mask   <= cfg_mask;
        shadow_bypass <= cfg_bypass;
      end
      if (accept) begin
        idx <= idx + NUM_BIT'(1);
        if (idx == '0) begin
          active_mask   <= shadow_mask;
          active_bypass <= shadow_bypass;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= marked ? neg_data : bus.in_data;
      bus.out_index <= idx;
      bus.out_last  <= (idx == '1);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // A saturating accept takes priority over the clear from a coincident cfg_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (accept && marked && neg_sat) begin
      sat_flag <= 1'b1;
    end else if (cfg_we) begin
      sat_flag <= 1'b0;
    end
  end
endmodule
